// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 32-bit masked memory port among NUM_REQ upstream requesters.
//   Each requester gets a one-deep pending buffer. Only one downstream
//   transaction is outstanding at a time. Grants are round-robin, and each
//   completion is routed back to the requester that issued it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   up_addr/rmask/wmask/     per-requester request; a nonzero mask in a cycle
//   up_wdata                 is one request, sampled at that clock edge
//   up_rdata, up_resp        per-requester read data and one-cycle completion
//   dn_addr/rmask/wmask/     downstream request; masks are nonzero only in
//   dn_wdata                 the issue cycle, addr/wdata hold otherwise
//   dn_rdata, dn_resp        downstream read data and completion pulse
//   error                    sticky protocol-violation flag
module mem_port_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0][31:0] up_addr,
  input  logic [NUM_REQ-1:0][3:0]  up_rmask,
  input  logic [NUM_REQ-1:0][3:0]  up_wmask,
  input  logic [NUM_REQ-1:0][31:0] up_wdata,
  output logic [NUM_REQ-1:0][31:0] up_rdata,
  output logic [NUM_REQ-1:0]       up_resp,
  output logic [31:0]              dn_addr,
  output logic [3:0]               dn_rmask,
  output logic [3:0]               dn_wmask,
  output logic [31:0]              dn_wdata,
  input  logic [31:0]              dn_rdata,
  input  logic                     dn_resp,
  output logic                     error
);

  localparam int OW = $clog2(NUM_REQ);
  localparam logic [OW-1:0] LAST_IDX = OW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]       pend_valid;
  logic [NUM_REQ-1:0][31:0] pend_addr;
  logic [NUM_REQ-1:0][3:0]  pend_rmask;
  logic [NUM_REQ-1:0][3:0]  pend_wmask;
  logic [NUM_REQ-1:0][31:0] pend_wdata;

  logic          out_valid;
  logic [OW-1:0] out_owner;
  logic [OW-1:0] last_grant;
  logic [31:0]   hold_addr;
  logic [31:0]   hold_wdata;

  logic          resp_fire;
  logic          stray_resp;
  logic          found;
  logic          issue;
  logic [OW-1:0] grant;
  logic [31:0]   idx;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] viol;

  // A response during reset is discarded, together with the transaction it
  // would have completed.
  assign resp_fire  = dn_resp && out_valid && !rst;
  assign stray_resp = dn_resp && !out_valid;

  // Round-robin search, starting just after the last winner.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant) + 32'(k)) % 32'(NUM_REQ);
      if (!found && pend_valid[idx[OW-1:0]]) begin
        found = 1'b1;
        grant = idx[OW-1:0];
      end
    end
  end

  // The completing transaction frees the port in the same cycle, so
  // back-to-back issue needs no idle cycle.
  assign issue = !rst && found && (!out_valid || dn_resp);

  always_comb begin
    dn_rmask = 4'h0;
    dn_wmask = 4'h0;
    dn_addr  = hold_addr;
    dn_wdata = hold_wdata;
    if (issue) begin
      dn_rmask = pend_rmask[grant];
      dn_wmask = pend_wmask[grant];
      dn_addr  = pend_addr[grant];
      dn_wdata = pend_wdata[grant];
    end
  end

  always_comb begin
    up_resp  = '0;
    up_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (resp_fire && (out_owner == OW'(i))) begin
        up_resp[i]  = 1'b1;
        up_rdata[i] = dn_rdata;
      end
    end
  end

  // A requester is busy while its entry is pending, or while its request is
  // outstanding downstream and not completing this cycle. A request from a
  // busy requester is dropped.
  always_comb begin
    req    = '0;
    busy   = '0;
    accept = '0;
    viol   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]    = (up_rmask[i] != 4'h0) || (up_wmask[i] != 4'h0);
      busy[i]   = pend_valid[i] ||
                  (out_valid && (out_owner == OW'(i)) && !up_resp[i]);
      accept[i] = req[i] && !busy[i];
      viol[i]   = req[i] && (busy[i] ||
                             ((up_rmask[i] != 4'h0) && (up_wmask[i] != 4'h0)) ||
                             (up_addr[i][1:0] != 2'b00));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= '0;
      pend_addr  <= '0;
      pend_rmask <= '0;
      pend_wmask <= '0;
      pend_wdata <= '0;
      out_valid  <= 1'b0;
      out_owner  <= '0;
      last_grant <= LAST_IDX;
      hold_addr  <= '0;
      hold_wdata <= '0;
      error      <= 1'b0;
    end else begin
      // Accept and issue never hit the same entry in one cycle. Accept needs
      // an empty entry, and issue needs a valid one.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && (grant == OW'(i))) begin
          pend_valid[i] <= 1'b0;
        end
        if (accept[i]) begin
          pend_valid[i] <= 1'b1;
          pend_addr[i]  <= up_addr[i];
          pend_rmask[i] <= up_rmask[i];
          pend_wmask[i] <= up_wmask[i];
          pend_wdata[i] <= up_wdata[i];
        end
      end

      if (issue) begin
        out_valid  <= 1'b1;
        out_owner  <= grant;
        last_grant <= grant;
        hold_addr  <= pend_addr[grant];
        hold_wdata <= pend_wdata[grant];
      end else if (resp_fire) begin
        out_valid <= 1'b0;
      end

      if ((viol != '0) || stray_resp) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0][31:0] up_addr = '0;
  logic [1:0][3:0]  up_rmask = '0;
  logic [1:0][3:0]  up_wmask = '0;
  logic [1:0][31:0] up_wdata = '0;
  logic [1:0][31:0] up_rdata;
  logic [1:0]       up_resp;
  logic [31:0]      dn_addr;
  logic [3:0]       dn_rmask;
  logic [3:0]       dn_wmask;
  logic [31:0]      dn_wdata;
  logic [31:0]      dn_rdata = '0;
  logic             dn_resp = 1'b0;
  logic             error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
  } iss_t;

  iss_t        exp_iss[$];
  logic [31:0] exp_rd0[$];
  logic [31:0] exp_rd1[$];

  int          lat = 3;
  int          rcnt = 0;
  logic [31:0] rd_next = '0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rd = '0;

  mem_port_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .up_addr(up_addr), .up_rmask(up_rmask), .up_wmask(up_wmask),
    .up_wdata(up_wdata), .up_rdata(up_rdata), .up_resp(up_resp),
    .dn_addr(dn_addr), .dn_rmask(dn_rmask), .dn_wmask(dn_wmask),
    .dn_wdata(dn_wdata), .dn_rdata(dn_rdata), .dn_resp(dn_resp),
    .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Downstream memory model: completes each issue lat cycles later.
  always @(posedge clk) begin
    #1;
    dn_resp  = 1'b0;
    dn_rdata = '0;
    if (rst) begin
      rcnt = 0;
    end else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        dn_resp  = 1'b1;
        dn_rdata = rd_next;
      end
    end
  end

  // Scoreboard: every downstream issue and every upstream response must
  // match the head of the corresponding expectation queue.
  always @(negedge clk) begin : mon
    iss_t        e;
    logic [31:0] v;
    if ((dn_rmask != 4'h0) || (dn_wmask != 4'h0)) begin
      checks++;
      if (exp_iss.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue addr=%h rmask=%h wmask=%h", dn_addr, dn_rmask, dn_wmask);
      end else begin
        e = exp_iss.pop_front();
        if (dn_addr !== e.addr || dn_rmask !== e.rm || dn_wmask !== e.wm ||
            (e.wm != 4'h0 && dn_wdata !== e.wd)) begin
          errors++;
          $display("FAIL issue got addr=%h rm=%h wm=%h wd=%h expected addr=%h rm=%h wm=%h wd=%h",
                   dn_addr, dn_rmask, dn_wmask, dn_wdata, e.addr, e.rm, e.wm, e.wd);
        end
      end
      rcnt    = lat;
      rd_next = use_fixed ? fixed_rd : rd_fn(dn_addr);
    end
    if (up_resp[0]) begin
      checks++;
      if (exp_rd0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp0 rdata=%h", up_rdata[0]);
      end else begin
        v = exp_rd0.pop_front();
        if (up_rdata[0] !== v) begin
          errors++;
          $display("FAIL resp0_rdata got=%h expected=%h", up_rdata[0], v);
        end
      end
    end
    if (up_resp[1]) begin
      checks++;
      if (exp_rd1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp1 rdata=%h", up_rdata[1]);
      end else begin
        v = exp_rd1.pop_front();
        if (up_rdata[1] !== v) begin
          errors++;
          $display("FAIL resp1_rdata got=%h expected=%h", up_rdata[1], v);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    up_rmask = '0;
    up_wmask = '0;
  endtask

  task automatic req(input int r, input logic [31:0] a, input logic [3:0] rm,
                     input logic [3:0] wm, input logic [31:0] wd);
    up_addr[r]  = a;
    up_rmask[r] = rm;
    up_wmask[r] = wm;
    up_wdata[r] = wd;
  endtask

  task automatic push_iss(input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
    iss_t e;
    e.addr = a; e.rm = rm; e.wm = wm; e.wd = wd;
    exp_iss.push_back(e);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    use_fixed = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req(0, 32'h0000_0800, 4'hF, 4'h0, 32'h0);
    cyc();
    @(negedge clk);
    checks++;
    if (dn_rmask !== 4'h0 || dn_wmask !== 4'h0 || up_resp !== 2'b00 || error !== 1'b0 ||
        dn_addr !== 32'h0 || dn_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state rm=%h wm=%h resp=%b err=%b addr=%h wd=%h expected all zero",
               dn_rmask, dn_wmask, up_resp, error, dn_addr, dn_wdata);
    end
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL reset_error got=%b expected=0", error);
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    lat = 5;
    use_fixed = 1'b1;
    fixed_rd = 32'hDEAD_BEEF;
    req(0, 32'h0000_1000, 4'hF, 4'h0, 32'h0);
    push_iss(32'h0000_1000, 4'hF, 4'h0, 32'h0);
    exp_rd0.push_back(32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    checks++;
    if (dn_rmask !== 4'hF || dn_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL single_issue rm=%h addr=%h expected rm=f addr=00001000", dn_rmask, dn_addr);
    end
    repeat (5) cyc();
    @(negedge clk);
    checks++;
    if (up_resp !== 2'b01 || up_rdata[0] !== 32'hDEAD_BEEF || up_rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL single_resp resp=%b rd0=%h rd1=%h expected resp=01 rd0=deadbeef rd1=0",
               up_resp, up_rdata[0], up_rdata[1]);
    end
    repeat (3) cyc();
    checks++;
    if (error !== 1'b0 || exp_iss.size() != 0 || exp_rd0.size() != 0) begin
      errors++;
      $display("FAIL single_drain err=%b iss_left=%0d rd_left=%0d expected 0", error, exp_iss.size(), exp_rd0.size());
    end
  endtask

  task automatic test_contention();
    apply_reset();
    lat = 4;
    req(0, 32'h0000_2000, 4'hF, 4'h0, 32'h0);
    req(1, 32'h0000_3000, 4'h0, 4'h3, 32'h0000_ABCD);
    push_iss(32'h0000_2000, 4'hF, 4'h0, 32'h0);
    push_iss(32'h0000_3000, 4'h0, 4'h3, 32'h0000_ABCD);
    exp_rd0.push_back(rd_fn(32'h0000_2000));
    exp_rd1.push_back(rd_fn(32'h0000_3000));
    cyc();
    @(negedge clk);
    checks++;
    if (dn_addr !== 32'h0000_2000 || dn_rmask !== 4'hF || dn_wmask !== 4'h0) begin
      errors++;
      $display("FAIL contention_first addr=%h rm=%h wm=%h expected 00002000 f 0", dn_addr, dn_rmask, dn_wmask);
    end
    repeat (4) cyc();
    @(negedge clk);
    checks++;
    if (up_resp !== 2'b01 || dn_wmask !== 4'h3 || dn_rmask !== 4'h0 ||
        dn_wdata !== 32'h0000_ABCD || dn_addr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL contention_b2b resp=%b wm=%h rm=%h wd=%h addr=%h expected 01 3 0 0000abcd 00003000",
               up_resp, dn_wmask, dn_rmask, dn_wdata, dn_addr);
    end
    repeat (6) cyc();
    checks++;
    if (error !== 1'b0 || exp_iss.size() != 0 || exp_rd0.size() != 0 || exp_rd1.size() != 0) begin
      errors++;
      $display("FAIL contention_drain err=%b iss_left=%0d expected 0", error, exp_iss.size());
    end
  endtask

  task automatic test_fairness();
    int sent[2];
    int got[2];
    int o;
    bit done;
    apply_reset();
    lat = 2;
    done = 1'b0;
    sent[0] = 1; sent[1] = 1; got[0] = 0; got[1] = 0;
    req(0, 32'h0001_0000, 4'hF, 4'h0, 32'h0);
    req(1, 32'h0002_0000, 4'hF, 4'h0, 32'h0);
    push_iss(32'h0001_0000, 4'hF, 4'h0, 32'h0);
    push_iss(32'h0002_0000, 4'hF, 4'h0, 32'h0);
    exp_rd0.push_back(rd_fn(32'h0001_0000));
    exp_rd1.push_back(rd_fn(32'h0002_0000));
    for (int c = 0; c < 200 && !done; c++) begin
      cyc();
      for (int r = 0; r < 2; r++) begin
        if (up_resp[r]) begin
          got[r]++;
          if (sent[r] < 10) begin
            logic [31:0] a;
            a = 32'((r + 1) << 16) + 32'(sent[r] * 4);
            req(r, a, 4'hF, 4'h0, 32'h0);
            push_iss(a, 4'hF, 4'h0, 32'h0);
            if (r == 0) exp_rd0.push_back(rd_fn(a));
            else        exp_rd1.push_back(rd_fn(a));
            sent[r]++;
          end
        end
      end
      @(negedge clk);
      if (up_resp != 2'b00) begin
        o = up_resp[0] ? 1 : 0;
        if (sent[o] > got[o]) begin
          checks++;
          if (dn_rmask !== 4'hF) begin
            errors++;
            $display("FAIL fair_no_idle cycle=%0d rm=%h expected f", c, dn_rmask);
          end
        end
      end
      if (got[0] == 10 && got[1] == 10) done = 1'b1;
    end
    checks++;
    if (got[0] != 10 || got[1] != 10) begin
      errors++;
      $display("FAIL fair_counts got0=%0d got1=%0d expected 10 10", got[0], got[1]);
    end
    repeat (3) cyc();
    checks++;
    if (error !== 1'b0 || exp_iss.size() != 0) begin
      errors++;
      $display("FAIL fair_drain err=%b iss_left=%0d expected 0 0", error, exp_iss.size());
    end
  endtask

  task automatic test_pipelined();
    bit seen;
    apply_reset();
    lat = 3;
    seen = 1'b0;
    req(0, 32'h0000_1000, 4'hF, 4'h0, 32'h0);
    push_iss(32'h0000_1000, 4'hF, 4'h0, 32'h0);
    exp_rd0.push_back(rd_fn(32'h0000_1000));
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc();
      if (up_resp[0]) begin
        seen = 1'b1;
        req(0, 32'h0000_1004, 4'hF, 4'h0, 32'h0);
        push_iss(32'h0000_1004, 4'hF, 4'h0, 32'h0);
        exp_rd0.push_back(rd_fn(32'h0000_1004));
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL pipe_timeout resp0 not seen within 20 cycles");
    end
    cyc();
    @(negedge clk);
    checks++;
    if (dn_rmask !== 4'hF || dn_addr !== 32'h0000_1004) begin
      errors++;
      $display("FAIL pipe_reissue rm=%h addr=%h expected f 00001004", dn_rmask, dn_addr);
    end
    repeat (5) cyc();
    checks++;
    if (error !== 1'b0 || exp_rd0.size() != 0) begin
      errors++;
      $display("FAIL pipe_drain err=%b rd_left=%0d expected 0 0", error, exp_rd0.size());
    end
  endtask

  task automatic test_err_both_masks();
    apply_reset();
    lat = 3;
    req(1, 32'h0000_4000, 4'hF, 4'h1, 32'h0000_0011);
    push_iss(32'h0000_4000, 4'hF, 4'h1, 32'h0000_0011);
    exp_rd1.push_back(rd_fn(32'h0000_4000));
    @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL err_both_early got=%b expected=0", error);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL err_both_set got=%b expected=1", error);
    end
    repeat (6) cyc();
    checks++;
    if (error !== 1'b1 || exp_rd1.size() != 0) begin
      errors++;
      $display("FAIL err_both_sticky got=%b rd_left=%0d expected 1 0", error, exp_rd1.size());
    end
  endtask

  task automatic test_err_duplicate();
    apply_reset();
    lat = 4;
    req(0, 32'h0000_5000, 4'hF, 4'h0, 32'h0);
    push_iss(32'h0000_5000, 4'hF, 4'h0, 32'h0);
    exp_rd0.push_back(rd_fn(32'h0000_5000));
    cyc();
    cyc();
    req(0, 32'h0000_5004, 4'hF, 4'h0, 32'h0);
    cyc();
    @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL err_dup_set got=%b expected=1", error);
    end
    repeat (8) cyc();
    checks++;
    if (error !== 1'b1 || exp_iss.size() != 0 || exp_rd0.size() != 0) begin
      errors++;
      $display("FAIL err_dup_drain err=%b iss_left=%0d rd_left=%0d expected 1 0 0",
               error, exp_iss.size(), exp_rd0.size());
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    lat = 5;
    req(0, 32'h0000_6000, 4'hF, 4'h0, 32'h0);
    req(1, 32'h0000_7000, 4'hF, 4'h0, 32'h0);
    push_iss(32'h0000_6000, 4'hF, 4'h0, 32'h0);
    cyc();
    @(negedge clk);
    checks++;
    if (dn_rmask !== 4'hF || dn_addr !== 32'h0000_6000) begin
      errors++;
      $display("FAIL mid_issue rm=%h addr=%h expected f 00006000", dn_rmask, dn_addr);
    end
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (dn_rmask !== 4'h0 || dn_wmask !== 4'h0 || up_resp !== 2'b00) begin
        errors++;
        $display("FAIL mid_in_reset rm=%h wm=%h resp=%b expected 0 0 00", dn_rmask, dn_wmask, up_resp);
      end
      cyc();
    end
    rst = 1'b0;
    repeat (8) cyc();
    req(1, 32'h0000_7100, 4'hF, 4'h0, 32'h0);
    push_iss(32'h0000_7100, 4'hF, 4'h0, 32'h0);
    exp_rd1.push_back(rd_fn(32'h0000_7100));
    cyc();
    @(negedge clk);
    checks++;
    if (dn_rmask !== 4'hF || dn_addr !== 32'h0000_7100) begin
      errors++;
      $display("FAIL mid_after_issue rm=%h addr=%h expected f 00007100", dn_rmask, dn_addr);
    end
    repeat (7) cyc();
    checks++;
    if (error !== 1'b0 || exp_iss.size() != 0 || exp_rd1.size() != 0 || exp_rd0.size() != 0) begin
      errors++;
      $display("FAIL mid_drain err=%b iss_left=%0d rd1_left=%0d expected 0 0 0",
               error, exp_iss.size(), exp_rd1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_pipelined();
    test_err_both_masks();
    test_err_duplicate();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit masked memory port (addr/rmask/wmask/wdata in; rdata/resp back) among NUM_REQ upstream requesters, e.g. the instruction fetch and data stages of the pipeline.
- Buffers one pending request per requester and issues at most one downstream request at a time.
- Grants by round-robin and routes the response back to the requester that issued it.
- Sits between the pipeline's memory stages and the single-channel pipeline memory model.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- up_addr  in  NUM_REQ x 32  request address per requester; 4-byte aligned.
- up_rmask  in  NUM_REQ x 4  byte read mask; nonzero = read request this cycle.
- up_wmask  in  NUM_REQ x 4  byte write mask; nonzero = write request this cycle.
- up_wdata  in  NUM_REQ x 32  write data.
- up_rdata  out  NUM_REQ x 32  read data; valid only with up_resp.
- up_resp  out  NUM_REQ x 1  one-cycle completion pulse.
- dn_addr  out  32  downstream address.
- dn_rmask  out  4  downstream read mask.
- dn_wmask  out  4  downstream write mask.
- dn_wdata  out  32  downstream write data.
- dn_rdata  in  32  downstream read data.
- dn_resp  in  1  downstream completion pulse.
- error  out  1  sticky protocol-violation flag.

Behaviour:
- Upstream protocol:
  - A request is a single cycle with nonzero rmask or wmask; addr, wdata and masks are sampled at that clk edge.
  - Each requester may have at most one request in flight.
  - A new request is legal in the same cycle that requester's up_resp is high, or any later cycle.
- Pending buffer:
  - Per requester: valid bit plus addr/rmask/wmask/wdata.
  - Loaded at the edge where the upstream request is seen.
  - Cleared at the edge where that entry is issued downstream.
  - No same-cycle bypass: the earliest downstream issue is the cycle after the upstream request.
- Downstream state: out_valid and out_owner (log2(NUM_REQ) bits).
  - Issue is allowed in a cycle when (!out_valid || dn_resp) and at least one pending entry is valid.
- Issue cycle:
  - dn_* are driven combinationally from the granted pending entry.
  - out_valid is set and out_owner is set to the grantee at the edge.
- Non-issue cycle: dn_rmask = dn_wmask = 0; dn_addr and dn_wdata hold their last issued values.
- Round-robin arbitration:
  - Pointer last_grant, reset value NUM_REQ-1.
  - Search starts at last_grant+1 mod NUM_REQ; the first valid pending entry wins.
  - last_grant is updated to the winner on issue.
- Response routing:
  - When dn_resp && out_valid: up_resp[out_owner] = 1 combinationally in the same cycle and up_rdata[out_owner] = dn_rdata.
  - The other up_resp bits are 0.
  - out_valid clears at the edge unless a new issue occurs in the same cycle.
  - Back-to-back operation is allowed: resp of request A and issue of request B in one cycle.
- Throughput: one transaction per dn_resp when every requester keeps a request pending.
- Stray dn_resp (dn_resp while !out_valid): ignored, and error is set.
- Error, sticky until rst, set at the edge following any of:
  - rmask and wmask both nonzero on one requester;
  - a new request while that requester's pending entry is valid, or while its request is outstanding downstream and no up_resp is given to it that cycle; the new request is dropped;
  - nonzero mask with addr[1:0] != 0;
  - a stray dn_resp.
- Reset values (rst high at an edge):
  - All pending valid bits 0, out_valid 0, out_owner 0, last_grant NUM_REQ-1, error 0.
  - dn_rmask = dn_wmask = 0 and up_resp = 0 while rst is high; dn_addr and dn_wdata reset to 0.
- Reset mid-transaction: the in-flight and pending requests are discarded with no up_resp; any dn_resp during rst is ignored.
- up_rdata outside a resp cycle is 0.

Test Plan:
- Single read: up_rmask[0]=4'hF, addr 0x1000 at cycle 0. Required: dn_rmask=4'hF, dn_addr=0x1000 in cycle 1. dn_resp with dn_rdata=0xDEADBEEF at cycle 6 must give up_resp[0]=1 and up_rdata[0]=0xDEADBEEF in cycle 6 and up_resp[1]=0.
- Contention: both requesters issue at cycle 0 (0: read 0x2000; 1: write 0x3000, wmask 4'h3, wdata 0x0000ABCD). Required: requester 0 is issued first (pointer after reset). In the cycle of its dn_resp, the requester-1 write is issued with dn_wmask=4'h3 and dn_wdata=0x0000ABCD.
- Fairness: both requesters re-request immediately on every resp, for 20 transactions. Required: grants alternate 0,1,0,1,…; each requester gets 10 up_resp; no idle downstream cycle between a resp and the next issue.
- Pipelined reissue: requester 0 issues its next read (0x1004) in the same cycle it receives up_resp. Required: it is accepted into pending and issued the next cycle; error stays 0.
- Protocol errors:
  - Requester 1 sends rmask=4'hF and wmask=4'h1 together: error=1 from the next cycle and stays 1.
  - Separate run: a second request from the same requester while its first is outstanding: error=1 and the second request is never issued.
- Reset mid-flight: assert rst one cycle after an issue with requester 1 also pending, then deassert. Required: no up_resp for either request; dn masks 0; the next request from requester 1 is issued normally; error=0.
